// File: rtl/phy_hard_reset_tx.sv
// -----------------------------------------------------------------------------
// phy_hard_reset_tx
//
// This is the downstream PHY transmit stage for Hard Reset and Cable Reset.
// A TRANSMIT write starts one request. The block first waits for the CC line
// to go idle. It then serializes an alternating preamble and the 4-K-code
// ordered set (5-bit codes, LSB first), one bit per BIT_DIV clocks. When it
// finishes, it reports to the alert logic with a one-cycle success or failure
// pulse.
//
// Ports
//   CLK              system clock
//   reset            synchronous, active-low reset
//   iTRANSMIT        TRANSMIT register value; only [2:0] is decoded
//                    (101 = Hard Reset, 110 = Cable Reset)
//   iTRANSMIT_valid  one-cycle strobe: iTRANSMIT was just written
//   iCC_busy         CC line activity detected
//   iStop_Attempting abort request from the protocol layer (level)
//   oTX_BIT          serial bit to the BMC encoder (0 whenever oTX_EN = 0)
//   oTX_EN           high while a bit is being driven
//   oBUSY            high in any state other than IDLE
//   oALERT_SUCCESS   one-cycle pulse: ordered set fully sent
//   oALERT_FAILED    one-cycle pulse: idle timeout or abort
//   oSENT_TYPE       type last sent (01 hard, 10 cable, 00 none)
//
// All outputs are registered. They are computed from the next state, so
// oTX_EN rises on the same edge that accepts a request on an idle line.
// -----------------------------------------------------------------------------
module phy_hard_reset_tx #(
    parameter int BIT_DIV       = 4,
    parameter int PREAMBLE_BITS = 64,
    parameter int IDLE_TIMEOUT  = 1000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] iTRANSMIT,
    input  logic       iTRANSMIT_valid,
    input  logic       iCC_busy,
    input  logic       iStop_Attempting,
    output logic       oTX_BIT,
    output logic       oTX_EN,
    output logic       oBUSY,
    output logic       oALERT_SUCCESS,
    output logic       oALERT_FAILED,
    output logic [1:0] oSENT_TYPE
);

    localparam int ORD_BITS = 20;
    localparam int DIV_W    = $clog2(BIT_DIV);
    localparam int PRE_W    = $clog2(PREAMBLE_BITS);
    localparam int ORD_W    = $clog2(ORD_BITS);
    localparam int WAIT_W   = $clog2(IDLE_TIMEOUT);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PREAMBLE_BITS - 1);
    localparam logic [ORD_W-1:0]  ORD_LAST  = ORD_W'(ORD_BITS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IDLE_TIMEOUT - 1);

    localparam logic [4:0] K_RST1  = 5'b00111;
    localparam logic [4:0] K_RST2  = 5'b11001;
    localparam logic [4:0] K_SYNC1 = 5'b11000;
    localparam logic [4:0] K_SYNC3 = 5'b00110;

    // The first K-code sits in the low bits, so bit index j of the vector is
    // the j-th bit on the wire.
    localparam logic [ORD_BITS-1:0] HARD_SEQ  = {K_RST2, K_RST1, K_RST1, K_RST1};
    localparam logic [ORD_BITS-1:0] CABLE_SEQ = {K_SYNC3, K_RST1, K_SYNC1, K_RST1};

    localparam logic [1:0] TYPE_NONE  = 2'b00;
    localparam logic [1:0] TYPE_HARD  = 2'b01;
    localparam logic [1:0] TYPE_CABLE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_PREAMBLE,
        S_ORDSET,
        S_DONE,
        S_FAIL
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [PRE_W-1:0]    r_pre;
    logic [ORD_W-1:0]    r_ord;
    logic [WAIT_W-1:0]   r_wait;
    logic [1:0]          r_type;
    logic                r_tx_bit;
    logic                r_tx_en;
    logic                r_busy;
    logic                r_alert_success;
    logic                r_alert_failed;
    logic [1:0]          r_sent_type;

    state_t              w_state_next;
    logic [DIV_W-1:0]    w_div_next;
    logic [PRE_W-1:0]    w_pre_next;
    logic [ORD_W-1:0]    w_ord_next;
    logic [WAIT_W-1:0]   w_wait_next;
    logic [1:0]          w_type_next;
    logic                w_tx_bit_next;
    logic                w_is_hard;
    logic                w_is_cable;
    logic                w_req_valid;
    logic                w_bit_done;
    logic [ORD_BITS-1:0] w_ord_seq;
    logic                w_unused;

    assign w_is_hard   = (iTRANSMIT[2:0] == 3'b101);
    assign w_is_cable  = (iTRANSMIT[2:0] == 3'b110);
    assign w_req_valid = iTRANSMIT_valid && (w_is_hard || w_is_cable);
    assign w_bit_done  = (r_div == DIV_LAST);
    assign w_ord_seq   = (r_type == TYPE_CABLE) ? CABLE_SEQ : HARD_SEQ;

    // The upper TRANSMIT bits carry no meaning for this stage.
    assign w_unused = ^iTRANSMIT[7:3];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_next = r_state;
        w_div_next   = r_div;
        w_pre_next   = r_pre;
        w_ord_next   = r_ord;
        w_wait_next  = r_wait;
        w_type_next  = r_type;

        case (r_state)
            S_IDLE: begin
                w_div_next  = '0;
                w_pre_next  = '0;
                w_ord_next  = '0;
                w_wait_next = '0;
                if (w_req_valid) begin
                    w_type_next  = w_is_hard ? TYPE_HARD : TYPE_CABLE;
                    w_state_next = iCC_busy ? S_WAIT_IDLE : S_PREAMBLE;
                end
            end

            // Abort is tested first in every active state, so it wins over
            // the idle, bit-complete and timeout transitions.
            S_WAIT_IDLE: begin
                if (iStop_Attempting) begin
                    w_state_next = S_FAIL;
                end else if (!iCC_busy) begin
                    w_state_next = S_PREAMBLE;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_next = S_FAIL;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
            end

            S_PREAMBLE: begin
                if (iStop_Attempting) begin
                    w_state_next = S_FAIL;
                end else if (w_bit_done) begin
                    w_div_next = '0;
                    if (r_pre == PRE_LAST) begin
                        w_state_next = S_ORDSET;
                        w_ord_next   = '0;
                    end else begin
                        w_pre_next = r_pre + 1'b1;
                    end
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end

            S_ORDSET: begin
                if (iStop_Attempting) begin
                    w_state_next = S_FAIL;
                end else if (w_bit_done) begin
                    w_div_next = '0;
                    if (r_ord == ORD_LAST) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_ord_next = r_ord + 1'b1;
                    end
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end

            S_DONE:  w_state_next = S_IDLE;
            S_FAIL:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase

        // The bit for the next cycle follows the next state and counters,
        // so the registered output lines up with the state it belongs to.
        case (w_state_next)
            S_PREAMBLE: w_tx_bit_next = w_pre_next[0];
            S_ORDSET:   w_tx_bit_next = w_ord_seq[w_ord_next];
            default:    w_tx_bit_next = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: the reset is synchronous. It clears the state, the counters and
        // every output register on the same edge. A transfer cut off by reset
        // therefore stops immediately and produces no alert pulse.
        if (!reset) begin
            r_state         <= S_IDLE;
            r_div           <= '0;
            r_pre           <= '0;
            r_ord           <= '0;
            r_wait          <= '0;
            r_type          <= TYPE_NONE;
            r_tx_bit        <= 1'b0;
            r_tx_en         <= 1'b0;
            r_busy          <= 1'b0;
            r_alert_success <= 1'b0;
            r_alert_failed  <= 1'b0;
            r_sent_type     <= TYPE_NONE;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before the edge.
            r_state         <= w_state_next;
            r_div           <= w_div_next;
            r_pre           <= w_pre_next;
            r_ord           <= w_ord_next;
            r_wait          <= w_wait_next;
            r_type          <= w_type_next;
            r_tx_bit        <= w_tx_bit_next;
            r_tx_en         <= (w_state_next == S_PREAMBLE) || (w_state_next == S_ORDSET);
            r_busy          <= (w_state_next != S_IDLE);
            r_alert_success <= (w_state_next == S_DONE);
            r_alert_failed  <= (w_state_next == S_FAIL);
            if (w_state_next == S_DONE) begin
                r_sent_type <= r_type;
            end
        end
    end

    assign oTX_BIT        = r_tx_bit;
    assign oTX_EN         = r_tx_en;
    assign oBUSY          = r_busy;
    assign oALERT_SUCCESS = r_alert_success;
    assign oALERT_FAILED  = r_alert_failed;
    assign oSENT_TYPE     = r_sent_type;

endmodule

// File: tb/tb_phy_hard_reset_tx.sv
// -----------------------------------------------------------------------------
// tb_phy_hard_reset_tx
//
// Self-checking bench for phy_hard_reset_tx with BIT_DIV = 2 and
// PREAMBLE_BITS = 64. Each table row describes one request and the outcome it
// must produce. Hand-written sequences cover reset behaviour.
// -----------------------------------------------------------------------------
module tb_phy_hard_reset_tx;

    localparam int BIT_DIV  = 2;
    localparam int PRE      = 64;
    localparam int TIMEOUT  = 1000;
    localparam int TOTAL    = PRE + 20;
    localparam int FULL_EN  = TOTAL * BIT_DIV;
    localparam int BUDGET   = 3000;

    logic       CLK = 1'b0;
    logic       reset;
    logic [7:0] iTRANSMIT;
    logic       iTRANSMIT_valid;
    logic       iCC_busy;
    logic       iStop_Attempting;
    logic       oTX_BIT;
    logic       oTX_EN;
    logic       oBUSY;
    logic       oALERT_SUCCESS;
    logic       oALERT_FAILED;
    logic [1:0] oSENT_TYPE;

    phy_hard_reset_tx #(
        .BIT_DIV      (BIT_DIV),
        .PREAMBLE_BITS(PRE),
        .IDLE_TIMEOUT (TIMEOUT)
    ) dut (
        .CLK             (CLK),
        .reset           (reset),
        .iTRANSMIT       (iTRANSMIT),
        .iTRANSMIT_valid (iTRANSMIT_valid),
        .iCC_busy        (iCC_busy),
        .iStop_Attempting(iStop_Attempting),
        .oTX_BIT         (oTX_BIT),
        .oTX_EN          (oTX_EN),
        .oBUSY           (oBUSY),
        .oALERT_SUCCESS  (oALERT_SUCCESS),
        .oALERT_FAILED   (oALERT_FAILED),
        .oSENT_TYPE      (oSENT_TYPE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Expected wire bit idx of a transfer of the given TRANSMIT code.
    function automatic logic exp_bit(input logic [2:0] code, input int idx);
        logic [4:0] sym;
        logic       cable;
        int         j;
        cable = (code == 3'b110);
        if (idx < PRE) return logic'(idx % 2);
        j = idx - PRE;
        case (j / 5)
            0:       sym = 5'b00111;                        // RST-1
            1:       sym = cable ? 5'b11000 : 5'b00111;     // Sync-1 / RST-1
            2:       sym = 5'b00111;                        // RST-1
            default: sym = cable ? 5'b00110 : 5'b11001;     // Sync-3 / RST-2
        endcase
        return sym[j % 5];
    endfunction

    typedef struct {
        string      name;
        logic [7:0] code;
        int         busy_clks;   // edges, from the strobe edge on, with CC busy
        int         abort_bit;   // ordered-set bit at which to abort, -1 = none
        int         restrobe;    // cycle of an extra 8'h05 strobe, -1 = none
        int         exp_en;      // clocks with oTX_EN high
        int         exp_first;   // cycle of the first oTX_EN high, -1 = never
        int         exp_succ;
        int         exp_fail;
        logic [1:0] exp_type;
    } vec_t;

    task automatic run_txn(input vec_t tv);
        int   en_cnt    = 0;
        int   first_en  = -1;
        int   last_en   = -1;
        int   succ_cnt  = 0;
        int   succ_cyc  = -1;
        int   fail_cnt  = 0;
        int   bit_err   = 0;
        int   idx;
        logic done      = 1'b0;
        logic stop_next = 1'b0;
        for (int c = 0; c < BUDGET && !done; c++) begin
            iTRANSMIT        = (c == tv.restrobe) ? 8'h05 : tv.code;
            iTRANSMIT_valid  = (c == 0) || (c == tv.restrobe);
            iCC_busy         = (c < tv.busy_clks);
            iStop_Attempting = stop_next;
            @(posedge CLK);
            @(negedge CLK);
            if (oTX_EN) begin
                idx = en_cnt / BIT_DIV;
                if (idx >= TOTAL || oTX_BIT !== exp_bit(tv.code[2:0], idx)) bit_err++;
                if (first_en < 0) first_en = c;
                last_en = c;
                if (tv.abort_bit >= 0 && en_cnt == (PRE + tv.abort_bit) * BIT_DIV)
                    stop_next = 1'b1;
                en_cnt++;
            end else if (oTX_BIT !== 1'b0) begin
                bit_err++;
            end
            if (oALERT_SUCCESS) begin
                succ_cnt++;
                succ_cyc = c;
            end
            if (oALERT_FAILED) fail_cnt++;
            if (c >= 4 && !oBUSY) done = 1'b1;
        end
        iTRANSMIT_valid  = 1'b0;
        iCC_busy         = 1'b0;
        iStop_Attempting = 1'b0;
        check({tv.name, ":returned_idle"}, int'(done), 1);
        check({tv.name, ":en_clocks"},     en_cnt,     tv.exp_en);
        check({tv.name, ":first_en"},      first_en,   tv.exp_first);
        check({tv.name, ":bit_errors"},    bit_err,    0);
        check({tv.name, ":success"},       succ_cnt,   tv.exp_succ);
        check({tv.name, ":failed"},        fail_cnt,   tv.exp_fail);
        check({tv.name, ":sent_type"},     int'(oSENT_TYPE), int'(tv.exp_type));
        if (tv.exp_succ > 0) check({tv.name, ":success_after_en"}, succ_cyc, last_en + 1);
        repeat (3) @(negedge CLK);
    endtask

    vec_t vecs[9];
    vec_t after_rst;
    int   pulses;

    initial begin
        vecs[0] = '{"hard_idle",    8'h05, 0,    -1, -1, FULL_EN, 0,  1, 0, 2'b01};
        vecs[1] = '{"cable_idle",   8'h06, 0,    -1, -1, FULL_EN, 0,  1, 0, 2'b10};
        vecs[2] = '{"hard_busy50",  8'h05, 50,   -1, -1, FULL_EN, 50, 1, 0, 2'b01};
        vecs[3] = '{"idle_timeout", 8'h06, 2000, -1, -1, 0,       -1, 0, 1, 2'b01};
        vecs[4] = '{"abort_ord7",   8'h06, 0,    7,  -1, (PRE + 7) * BIT_DIV + 1, 0, 0, 1, 2'b01};
        vecs[5] = '{"ignored_03",   8'h03, 0,    -1, -1, 0,       -1, 0, 0, 2'b01};
        vecs[6] = '{"ignored_07",   8'h07, 0,    -1, -1, 0,       -1, 0, 0, 2'b01};
        vecs[7] = '{"restrobe",     8'h06, 0,    -1, 20, FULL_EN, 0,  1, 0, 2'b10};
        vecs[8] = '{"upper_bits",   8'hF5, 0,    -1, -1, FULL_EN, 0,  1, 0, 2'b01};
        after_rst = '{"after_reset", 8'h06, 0,   -1, -1, FULL_EN, 0,  1, 0, 2'b10};

        reset            = 1'b0;
        iTRANSMIT        = 8'h00;
        iTRANSMIT_valid  = 1'b0;
        iCC_busy         = 1'b0;
        iStop_Attempting = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset:tx_en",     int'(oTX_EN),         0);
        check("reset:tx_bit",    int'(oTX_BIT),        0);
        check("reset:busy",      int'(oBUSY),          0);
        check("reset:success",   int'(oALERT_SUCCESS), 0);
        check("reset:failed",    int'(oALERT_FAILED),  0);
        check("reset:sent_type", int'(oSENT_TYPE),     0);
        reset = 1'b1;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // Reset in the middle of the preamble of a cable request.
        iTRANSMIT       = 8'h06;
        iTRANSMIT_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        iTRANSMIT_valid = 1'b0;
        repeat (30) @(negedge CLK);
        check("mid_pre:tx_en_before", int'(oTX_EN), 1);
        reset = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        check("mid_pre:tx_en",     int'(oTX_EN),         0);
        check("mid_pre:tx_bit",    int'(oTX_BIT),        0);
        check("mid_pre:busy",      int'(oBUSY),          0);
        check("mid_pre:success",   int'(oALERT_SUCCESS), 0);
        check("mid_pre:failed",    int'(oALERT_FAILED),  0);
        check("mid_pre:sent_type", int'(oSENT_TYPE),     0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (oALERT_SUCCESS || oALERT_FAILED || oTX_EN) pulses++;
        end
        check("mid_pre:quiet_after", pulses, 0);

        run_txn(after_rst);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/phy_hard_reset_tx.md
Name: phy_hard_reset_tx

Overview:
- Downstream PHY transmit stage for hard and cable resets.
- Accepts the TRANSMIT command written by the protocol-layer reset FSM: TRANSMIT[2:0] = 3'b101 is Hard Reset, 3'b110 is Cable Reset.
- Waits for the CC line to go idle, then serializes preamble plus the 4-K-code ordered set as 5-bit codes, LSB first, one bit per BIT_DIV clocks.
- Reports completion back to the alert logic with one-cycle success or failure pulses.

Parameters:
- BIT_DIV, 4: clocks per transmitted bit (≥2).
- PREAMBLE_BITS, 64: number of alternating preamble bits, starting with 0.
- IDLE_TIMEOUT, 1000: maximum clocks to wait for CC idle before failing.

Ports:
- CLK  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- iTRANSMIT  input  8  TRANSMIT register value; only bits [2:0] are decoded.
- iTRANSMIT_valid  input  1  one-cycle strobe: iTRANSMIT was just written.
- iCC_busy  input  1  CC line activity detected.
- iStop_Attempting  input  1  abort request from the protocol layer (level).
- oTX_BIT  output  1  serial bit to the BMC encoder.
- oTX_EN  output  1  high while a bit is being driven.
- oBUSY  output  1  high in any state other than IDLE.
- oALERT_SUCCESS  output  1  one-cycle pulse: ordered set fully sent.
- oALERT_FAILED  output  1  one-cycle pulse: timeout or abort.
- oSENT_TYPE  output  2  type last sent, held until the next request: 01 = hard, 10 = cable, 00 = none.

Behaviour:
- Reset (reset == 0 at a CLK edge):
  - state = IDLE.
  - oTX_BIT, oTX_EN, oBUSY, oALERT_SUCCESS, oALERT_FAILED = 0; oSENT_TYPE = 00.
  - All counters cleared.
  - Reset mid-transmission truncates output immediately at that edge; no alert pulse is produced.
- States: IDLE, WAIT_IDLE, PREAMBLE, ORDSET, DONE, FAIL.
- IDLE:
  - Exits only on iTRANSMIT_valid = 1 with iTRANSMIT[2:0] ∈ {101, 110}. Any other code is ignored.
  - The type is latched at that edge. If iCC_busy = 0 at the same edge, go to PREAMBLE; otherwise go to WAIT_IDLE.
- WAIT_IDLE:
  - A wait counter increments each clock.
  - iCC_busy = 0 → PREAMBLE.
  - Counter reaching IDLE_TIMEOUT-1 while still busy → FAIL.
- PREAMBLE:
  - oTX_EN = 1. Bit k (k = 0..PREAMBLE_BITS-1) equals k[0]; the first bit is 0.
  - Each bit is held exactly BIT_DIV clocks, timed by a divider counter 0..BIT_DIV-1.
  - After the last bit → ORDSET.
- ORDSET: 20 bits, each 5-bit code sent LSB first.
  - Hard Reset: RST-1, RST-1, RST-1, RST-2.
  - Cable Reset: RST-1, Sync-1, RST-1, Sync-3.
  - Code values: RST-1 = 5'b00111, RST-2 = 5'b11001, Sync-1 = 5'b11000, Sync-3 = 5'b00110.
  - After bit 19 completes → DONE.
- DONE:
  - Lasts one cycle; oTX_EN = 0, oALERT_SUCCESS = 1.
  - oSENT_TYPE is updated to the latched type.
  - → IDLE.
- FAIL:
  - Lasts one cycle; oTX_EN = 0, oALERT_FAILED = 1; oSENT_TYPE is unchanged.
  - → IDLE.
- Abort: iStop_Attempting = 1 in WAIT_IDLE, PREAMBLE or ORDSET → FAIL at the next edge.
  - Abort takes priority over the idle, bit-complete and timeout transitions.
- Timing:
  - Latency from a valid strobe (line idle) to the first oTX_EN = 1 is 1 clock.
  - oTX_EN stays high for exactly (PREAMBLE_BITS+20)*BIT_DIV consecutive clocks.
  - The success pulse occurs in the cycle right after oTX_EN falls.
- Requests while busy:
  - iTRANSMIT_valid while oBUSY = 1 is ignored. There is no queue, and the latched type does not change.
- Outputs are registered; oTX_BIT = 0 whenever oTX_EN = 0.
- iCC_busy is sampled only in IDLE (at the request edge) and in WAIT_IDLE. The block does not check for collisions once transmission has started.
- Counter widths are sized by $clog2 of their respective parameters; no counter may wrap within a state.

Test Plan:
- Hard reset, line idle (BIT_DIV = 2, PREAMBLE_BITS = 64): valid strobe with iTRANSMIT = 8'h05.
  - oTX_EN is high for 168 clocks.
  - Bits 64..83 are 1110011100111001 0011.
  - oALERT_SUCCESS pulses once; oSENT_TYPE = 01.
- Cable reset: iTRANSMIT = 8'h06.
  - Ordered-set bits are 11100 00011 11100 01100.
  - Success pulse; oSENT_TYPE = 10.
- Busy line: iCC_busy = 1 for 50 clocks after the strobe.
  - oTX_EN rises at clock 51 and the full sequence is sent.
  - Separately: busy held ≥ IDLE_TIMEOUT clocks → oALERT_FAILED pulse, oTX_EN never asserted.
- Abort mid-ORDSET: assert iStop_Attempting at ordered-set bit 7.
  - oTX_EN drops at the next edge, one oALERT_FAILED pulse, oSENT_TYPE unchanged.
- Ignored requests:
  - iTRANSMIT = 8'h03 → no activity.
  - A second 8'h05 strobe during PREAMBLE → a single transmission and a single success pulse.
- Reset mid-PREAMBLE: reset = 0 for 1 clock.
  - All outputs are 0 at the next edge, no alert pulses.
  - A new request afterwards completes normally.
